// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants for the Basys 3 four-digit seven-segment controller:
// FSM encoding, anode patterns and active-low segment codes (bit 0 = a, bit 6 = g).
package seg_display_ctrl_pkg;

    localparam int BIN_W = 14;
    localparam int BCD_W = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] an_code(input logic [1:0] idx);
        case (idx)
            2'd0:    an_code = AN_DIG0;
            2'd1:    an_code = AN_DIG1;
            2'd2:    an_code = AN_DIG2;
            default: an_code = AN_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble converter: 14 steps after start, one per clock.
// done is high during the final step, so bcd holds the result from the next edge on.
module seg_bin2bcd
    import seg_display_ctrl_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESETN,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic [BCD_W+BIN_W-1:0] sr;
    logic [BCD_W+BIN_W-1:0] step;
    logic [3:0]             cnt;

    always_comb begin
        step = sr;
        for (int k = 0; k < 4; k++) begin
            if (step[BIN_W+4*k +: 4] >= 4'd5)
                step[BIN_W+4*k +: 4] = step[BIN_W+4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= {{BCD_W{1'b0}}, bin};
            cnt <= 4'(BIN_W);
        end else if (cnt != 4'd0) begin
            sr  <= {step[BCD_W+BIN_W-2:0], 1'b0};
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd1);
    assign bcd  = sr[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit seven-segment controller: accepts a binary value, converts it to BCD and
// scans the digits with per-slot ghost blanking and optional leading-zero suppression.
//
//   state     | meaning
//   ST_IDLE   | waiting for a value; in_ready high
//   ST_CONV   | double-dabble conversion running (14 cycles)
//   ST_COMMIT | digits and ovf written together in one edge
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 200000,
    parameter int BLANK_CYC = 1000,
    parameter int LZB       = 1
) (
    input  logic             CLOCK,
    input  logic             RESETN,
    input  logic [BIN_W-1:0] number,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             ovf,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    state_t           state;
    logic             ovf_pend;
    logic [BCD_W-1:0] digits;
    logic             conv_start;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             too_big;

    logic [PW-1:0]    presc;
    logic [1:0]       idx;
    logic [3:0]       cur_digit;
    logic             lead_zero;
    logic [6:0]       seg_nx;
    logic [3:0]       an_nx;

    assign in_ready   = (state == ST_IDLE);
    assign busy       = ~in_ready;
    assign too_big    = (number > 14'd9999);
    assign conv_start = in_ready & in_valid & ~too_big;

    seg_bin2bcd u_bin2bcd (
        .CLOCK  (CLOCK),
        .RESETN (RESETN),
        .start  (conv_start),
        .bin    (number),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= ST_IDLE;
            ovf_pend <= 1'b0;
            digits   <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ovf_pend <= too_big;
                        state    <= too_big ? ST_COMMIT : ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // overflow keeps the old digits; they are hidden behind dashes anyway
                    ovf <= ovf_pend;
                    if (!ovf_pend)
                        digits <= conv_bcd;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        cur_digit = digits[{idx, 2'b00} +: 4];
        case (idx)
            2'd1:    lead_zero = (digits[15:4]  == 12'd0);
            2'd2:    lead_zero = (digits[15:8]  == 8'd0);
            2'd3:    lead_zero = (digits[15:12] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
        seg_nx = SEG_BLANK;
        an_nx  = AN_OFF;
        if (presc >= BLANK_END) begin
            if (ovf) begin
                seg_nx = SEG_DASH;
                an_nx  = an_code(idx);
            end else if (!((LZB != 0) && lead_zero)) begin
                seg_nx = seg_code(cur_digit);
                an_nx  = an_code(idx);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nx;
            an  <= an_nx;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: stimulus queues the expected display per value,
// a monitor checks latency, ovf and one full scan round of both an LZB=1 and an LZB=0 instance.
module tb_seg_display_ctrl;

    localparam logic [6:0] B = 7'h7F;        // slot blanked
    localparam logic [6:0] Z = 7'b1000000;   // digit 0
    localparam logic [6:0] D = 7'b0111111;   // dash

    logic        CLOCK = 1'b0;
    logic        RESETN = 1'b0;
    logic [13:0] number = 14'd0;
    logic        in_valid = 1'b0;

    logic        in_ready, busy, ovf;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        in_ready_b, busy_b, ovf_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    always #5 CLOCK = ~CLOCK;

    seg_display_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .LZB(1)) u_dut (
        .CLOCK(CLOCK), .RESETN(RESETN), .number(number), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .ovf(ovf), .seg(seg), .an(an)
    );

    seg_display_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .LZB(0)) u_dut_nolzb (
        .CLOCK(CLOCK), .RESETN(RESETN), .number(number), .in_valid(in_valid),
        .in_ready(in_ready_b), .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .an(an_b)
    );

    // sa/sb: expected segments per slot {slot3, slot2, slot1, slot0}; B means the slot stays dark
    typedef struct {
        int               tag;
        int               busy_len;
        logic             ovf;
        bit               win;
        logic [3:0][6:0]  sa;
        logic [3:0][6:0]  sb;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   probe_cnt = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    endtask

    function automatic exp_t mk(input int tag, input int bl, input logic o, input bit w,
                                input logic [27:0] a, input logic [27:0] b);
        exp_t e;
        e.tag = tag; e.busy_len = bl; e.ovf = o; e.win = w;
        e.sa = a; e.sb = b;
        return e;
    endfunction

    function automatic int slot_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            4'b1111: return -1;
            default: return -2;
        endcase
    endfunction

    task automatic settle(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic send(input logic [13:0] v);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge CLOCK); #1;
            n++;
        end
        if (n >= 100) chk("send_ready_timeout", 0, 1);
        number   = v;
        in_valid = 1'b1;
        @(posedge CLOCK); #1;
        in_valid = 1'b0;
    endtask

    // monitor: fires on every busy fall (commit) or on a stimulus probe
    initial begin : monitor
        int   busy_run;
        logic busy_q;
        int   seen_probe;
        bit   trig;
        exp_t e;
        int   cnt_a[4];
        int   cnt_b[4];
        int   bad_a, bad_b, k;
        busy_run = 0; busy_q = 1'b0; seen_probe = 0;
        forever begin
            @(negedge CLOCK);
            if (!RESETN) begin
                busy_run = 0;
                busy_q   = 1'b0;
                continue;
            end
            trig = 1'b0;
            if (busy) busy_run++;
            else if (busy_q) trig = 1'b1;
            if (probe_cnt != seen_probe) begin
                seen_probe = probe_cnt;
                trig = 1'b1;
            end
            busy_q = busy;
            if (!trig) continue;
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 1, 0);
                continue;
            end
            e = exp_q.pop_front();
            if (e.busy_len > 0)
                chk($sformatf("t%0d_busy_cycles", e.tag), busy_run, e.busy_len);
            busy_run = 0;
            chk($sformatf("t%0d_ovf", e.tag), ovf, e.ovf);
            chk($sformatf("t%0d_ovf_nolzb", e.tag), ovf_b, e.ovf);
            chk($sformatf("t%0d_nolzb_idle", e.tag), in_ready_b & ~busy_b, 1);
            if (!e.win) continue;
            @(negedge CLOCK);
            for (int i = 0; i < 4; i++) begin
                cnt_a[i] = 0;
                cnt_b[i] = 0;
            end
            bad_a = 0; bad_b = 0;
            for (int c = 0; c < 32; c++) begin
                @(negedge CLOCK);
                k = slot_of(an);
                if (k == -1) begin
                    if (seg != B) bad_a++;
                end else if (k < 0) bad_a++;
                else begin
                    cnt_a[k]++;
                    if (seg != e.sa[k]) begin
                        bad_a++;
                        $display("FAIL t%0d_seg_slot%0d: got %b, expected %b", e.tag, k, seg, e.sa[k]);
                    end
                end
                k = slot_of(an_b);
                if (k == -1) begin
                    if (seg_b != B) bad_b++;
                end else if (k < 0) bad_b++;
                else begin
                    cnt_b[k]++;
                    if (seg_b != e.sb[k]) begin
                        bad_b++;
                        $display("FAIL t%0d_nolzb_seg_slot%0d: got %b, expected %b", e.tag, k, seg_b, e.sb[k]);
                    end
                end
            end
            chk($sformatf("t%0d_scan_bad_cycles", e.tag), bad_a, 0);
            chk($sformatf("t%0d_nolzb_scan_bad_cycles", e.tag), bad_b, 0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t%0d_slot%0d_lit_cycles", e.tag, i), cnt_a[i], (e.sa[i] == B) ? 0 : 6);
                chk($sformatf("t%0d_nolzb_slot%0d_lit_cycles", e.tag, i), cnt_b[i], (e.sb[i] == B) ? 0 : 6);
            end
        end
    end

    initial begin : stim
        int n;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        RESETN = 1'b1;
        exp_q.push_back(mk(0, 0, 1'b0, 1'b1, {B, B, B, Z}, {Z, Z, Z, Z}));
        probe_cnt++;
        settle(45);

        exp_q.push_back(mk(1, 15, 1'b0, 1'b1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                                              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
        send(14'd1234);
        settle(60);

        exp_q.push_back(mk(2, 15, 1'b0, 1'b1, {B, B, B, 7'b1111000}, {Z, Z, Z, 7'b1111000}));
        send(14'd7);
        settle(60);

        exp_q.push_back(mk(3, 1, 1'b1, 1'b1, {D, D, D, D}, {D, D, D, D}));
        send(14'd12000);
        settle(45);

        exp_q.push_back(mk(4, 15, 1'b0, 1'b1, {B, B, 7'b0011001, 7'b0100100},
                                              {Z, Z, 7'b0011001, 7'b0100100}));
        send(14'd42);
        settle(60);

        // 100 is held valid while 1234 converts; it must wait for in_ready
        exp_q.push_back(mk(5, 15, 1'b0, 1'b0, '0, '0));
        exp_q.push_back(mk(6, 15, 1'b0, 1'b1, {B, 7'b1111001, Z, Z}, {Z, 7'b1111001, Z, Z}));
        send(14'd1234);
        number   = 14'd100;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            n++;
            @(posedge CLOCK); #1;
        end
        chk("held_valid_ready_low_cycles", n, 15);
        @(posedge CLOCK); #1;
        in_valid = 1'b0;
        settle(60);

        // reset in the middle of a conversion
        send(14'd1234);
        repeat (6) @(posedge CLOCK);
        #3;
        RESETN = 1'b0;
        #1;
        chk("midconv_rst_seg", seg, 7'h7F);
        chk("midconv_rst_an", an, 4'hF);
        chk("midconv_rst_busy", busy, 0);
        repeat (2) @(negedge CLOCK);
        @(posedge CLOCK); #1;
        RESETN = 1'b1;
        chk("midconv_post_rst_ready", in_ready, 1);
        exp_q.push_back(mk(7, 0, 1'b0, 1'b1, {B, B, B, Z}, {Z, Z, Z, Z}));
        probe_cnt++;
        settle(45);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Controller for the Basys 3 four-digit 7-segment display (100 MHz CLOCK).
- Accepts a 14-bit binary value over a valid/ready handshake.
- Converts it to BCD with a multi-cycle sequential converter and commits all four digits atomically.
- Time-multiplexes the anodes with a prescaled scan, inter-digit ghost blanking and optional leading-zero suppression.
- Sits between application logic and the board pins as the single owner of seg/an.

Parameters:
SCAN_DIV, 200000, CLOCK cycles per digit slot; must be > BLANK_CYC.
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off (anti-ghosting).
LZB, 1, 1 = blank leading zeros; digit 0 is never blanked.

Ports:
CLOCK  in  1  system clock, 100 MHz.
RESETN  in  1  asynchronous active-low reset.
number  in  14  binary value to display; sampled on accept.
in_valid  in  1  number is valid.
in_ready  out  1  controller can accept; high only in IDLE.
busy  out  1  conversion/commit in progress.
ovf  out  1  last committed value was > 9999; registered.
seg  out  7  segments, active-low, seg[0]=a … seg[6]=g; registered.
an  out  4  anodes, active-low, an[k] = digit k (k=0 is the ones digit); registered.

Behaviour:
- Reset (RESETN low, asynchronous):
  - Outputs: seg=7'h7F, an=4'hF, in_ready=1, busy=0, ovf=0.
  - Internal: digit regs=0, scan counter=0, digit index=0, FSM=IDLE.
  - Reset asserted mid-conversion aborts the conversion; no partial commit occurs.
- FSM: IDLE, CONV, COMMIT.
  - IDLE: in_ready=1. Accept when in_valid & in_ready.
    - number > 9999: go to COMMIT with overflow flag set.
    - Otherwise: load shift register, go to CONV.
  - CONV: exactly 14 cycles, one double-dabble step per cycle (add 3 to any BCD nibble ≥5, then shift left 1). in_valid is ignored.
  - COMMIT: 1 cycle. Write the 4 BCD digits and ovf together, then go to IDLE.
  - Latency: accept edge → display regs updated 15 edges later (normal value) or 1 edge later (overflow). in_ready returns high the cycle after COMMIT.
  - busy = (state != IDLE).
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously and is independent of the FSM.
  - On wrap, digit index increments mod 4 (0→1→2→3→0).
  - Anode pattern: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
  - While prescaler < BLANK_CYC: an=4'hF, seg=7'h7F.
  - A COMMIT does not reset the scan position; new digits appear from the next output register update.
- Segment content:
  - Digit 0..9 decodes to standard active-low codes, e.g. 0=1000000, 1=1111001.
  - ovf=1: every digit shows a dash, 7'b0111111. LZB does not apply.
  - LZB=1: digit k (k≥1) is blanked when it and every higher digit are 0. While blanked, an for that slot stays 4'hF and seg=7'h7F.
- Widths: prescaler width $clog2(SCAN_DIV). BCD shift register is 16+14 bits.

Decomposition:
- Shared package: anode pattern constants, SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, the 0-9 segment code table, FSM state encoding.
- One sub-module: seg_bin2bcd, the sequential double-dabble converter.
  - Inputs: start, bin[13:0].
  - Outputs: done, bcd[15:0].
  - Latency: 14 cycles.
  - Shares CLOCK and RESETN.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, LZB=1 unless noted.
1. Reset: hold RESETN low → seg=7F, an=F, in_ready=1, busy=0. After release, only slot idx0 drives an=1110 with seg=1000000; other slots keep an=1111. Cycles 0-1 of every slot are blank.
2. Send 1234 with a 1-cycle valid → in_ready=0 for 15 cycles, then one slot each:
   - an=1110, seg=0011001 (4)
   - an=1101, seg=0110000 (3)
   - an=1011, seg=0100100 (2)
   - an=0111, seg=1111001 (1)
3. Send 7 → only an=1110 is ever asserted, with seg=1111000. Repeat with LZB=0: all four anodes assert; digits 1-3 show 1000000.
4. Send 12000 → ovf=1 one edge after accept; all four slots show 0111111. Then send 42 → ovf=0, display shows 42 with two blanked digits.
5. Hold in_valid with 100 during a 1234 conversion → second value not accepted until in_ready=1. Then 100 is accepted; the display never shows a mix of digits from the two values.
6. Assert RESETN mid-CONV (cycle 7) → seg=7F and an=F immediately (asynchronous), busy=0. After release, display shows 0 and in_ready=1.
